oam_dma_engine: RTL and testbench

Bus initiator for the byte-wide asynchronous memory interface: combinational read while rd_cs is high, write on the clock edge while wr_cs is high. Implements Game Boy OAM DMA. A CPU write of a source high byte triggers a copy of LEN bytes from {src_hi, 8'h00} to DST_BASE. It sits between the CPU register decode (FF46) and the shared memory bus, and drives busy to stall CPU bus access during a transfer.

---
 rtl/gb_dma_pkg.sv | 19 +
 rtl/oam_dma_engine.sv | 121 ++++++++++++
 tb/tb_oam_dma_engine.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gb_dma_pkg.sv
// Shared types and constants for the Game Boy OAM DMA engine.
package gb_dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } dma_state_t;

  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam int          OAM_LEN      = 160;
  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;

  // Source address: the page byte is used as-is and the low byte never carries into it.
  function automatic logic [15:0] src_addr(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// OAM DMA bus initiator: copies LEN bytes from {src_hi, 8'h00} to DST_BASE,
// alternating a combinational-read cycle and a clocked-write cycle per byte.
// All bus outputs come from registers, so cfg_* never reaches mem_* combinationally.
module oam_dma_engine
  import gb_dma_pkg::*;
#(
  parameter int             LEN      = OAM_LEN,
  parameter int             ASZ      = 16,
  parameter logic [ASZ-1:0] DST_BASE = ASZ'(OAM_BASE)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cfg_wr,
  input  logic [7:0]     cfg_data,
  output logic [ASZ-1:0] mem_addr,
  output logic           mem_rd_cs,
  input  logic [7:0]     mem_rd_data,
  output logic           mem_wr_cs,
  output logic [7:0]     mem_wr_data,
  output logic           busy,
  output logic           done
);

  localparam logic [7:0] IDX_LAST = 8'(LEN - 1);

  dma_state_t     state_q;
  logic [7:0]     idx_q;
  logic [7:0]     src_hi_q;
  logic [7:0]     data_q;
  logic [ASZ-1:0] addr_q;
  logic           rd_cs_q;
  logic           wr_cs_q;
  logic           busy_q;
  logic           done_q;

  logic [7:0]     idx_inc_d;
  logic [ASZ-1:0] wr_addr_d;
  logic [ASZ-1:0] nxt_rd_addr_d;

  // Address arithmetic for the upcoming write and the next read.
  always_comb begin
    idx_inc_d     = idx_q + 8'd1;
    wr_addr_d     = DST_BASE + ASZ'(idx_q);
    nxt_rd_addr_d = ASZ'(src_addr(src_hi_q, idx_inc_d));
  end

  // Transfer FSM with registered bus outputs; a new cfg_wr always wins and restarts.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= 8'd0;
      src_hi_q <= 8'd0;
      data_q   <= 8'd0;
      addr_q   <= '0;
      rd_cs_q  <= 1'b0;
      wr_cs_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == RD) begin
        data_q <= mem_rd_data;
      end
      if (cfg_wr) begin
        state_q  <= RD;
        src_hi_q <= cfg_data;
        idx_q    <= 8'd0;
        addr_q   <= ASZ'(src_addr(cfg_data, 8'h00));
        rd_cs_q  <= 1'b1;
        wr_cs_q  <= 1'b0;
        busy_q   <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            rd_cs_q <= 1'b0;
            wr_cs_q <= 1'b0;
            busy_q  <= 1'b0;
          end
          RD: begin
            state_q <= WR;
            addr_q  <= wr_addr_d;
            rd_cs_q <= 1'b0;
            wr_cs_q <= 1'b1;
            busy_q  <= 1'b1;
          end
          WR: begin
            if (idx_q == IDX_LAST) begin
              state_q <= IDLE;
              rd_cs_q <= 1'b0;
              wr_cs_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= RD;
              idx_q   <= idx_inc_d;
              addr_q  <= nxt_rd_addr_d;
              rd_cs_q <= 1'b1;
              wr_cs_q <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            rd_cs_q <= 1'b0;
            wr_cs_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Reset gates the write select so an aborting reset never lets a write land.
  assign mem_wr_cs   = wr_cs_q & ~reset;
  assign mem_addr    = addr_q;
  assign mem_rd_cs   = rd_cs_q;
  assign mem_wr_data = data_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_oam_dma_engine.sv
// Directed bench for oam_dma_engine: default, LEN=1 and LEN=256 instances,
// each with an async source RAM read port and its own OAM page.
module tb_oam_dma_engine;
  import gb_dma_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [7:0]  cfg_data;
  logic        cfg_wr_a, cfg_wr_b, cfg_wr_c;
  logic [15:0] addr_a, addr_b, addr_c;
  logic        rd_a, rd_b, rd_c, wr_a, wr_b, wr_c;
  logic [7:0]  rdata_a, rdata_b, rdata_c, wdata_a, wdata_b, wdata_c;
  logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;

  logic [7:0]  ram   [0:65535];
  logic [7:0]  oam_a [0:255];
  logic [7:0]  oam_b [0:255];
  logic [7:0]  oam_c [0:255];
  logic        clr;
  logic [7:0]  clr_val;

  int checks = 0;
  int errors = 0;
  int overlap = 0;

  oam_dma_engine u_a (.clk(clk), .reset(reset), .cfg_wr(cfg_wr_a), .cfg_data(cfg_data),
    .mem_addr(addr_a), .mem_rd_cs(rd_a), .mem_rd_data(rdata_a), .mem_wr_cs(wr_a),
    .mem_wr_data(wdata_a), .busy(busy_a), .done(done_a));
  oam_dma_engine #(.LEN(1)) u_b (.clk(clk), .reset(reset), .cfg_wr(cfg_wr_b), .cfg_data(cfg_data),
    .mem_addr(addr_b), .mem_rd_cs(rd_b), .mem_rd_data(rdata_b), .mem_wr_cs(wr_b),
    .mem_wr_data(wdata_b), .busy(busy_b), .done(done_b));
  oam_dma_engine #(.LEN(256)) u_c (.clk(clk), .reset(reset), .cfg_wr(cfg_wr_c), .cfg_data(cfg_data),
    .mem_addr(addr_c), .mem_rd_cs(rd_c), .mem_rd_data(rdata_c), .mem_wr_cs(wr_c),
    .mem_wr_data(wdata_c), .busy(busy_c), .done(done_c));

  assign rdata_a = rd_a ? ((addr_a[15:8] == 8'hFE) ? oam_a[addr_a[7:0]] : ram[addr_a]) : 8'h00;
  assign rdata_b = rd_b ? ram[addr_b] : 8'h00;
  assign rdata_c = rd_c ? ram[addr_c] : 8'h00;

  // OAM pages: write on the clock edge while wr_cs is high, or bulk clear.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) begin
        oam_a[i] <= clr_val;
        oam_b[i] <= clr_val;
        oam_c[i] <= clr_val;
      end
    end else begin
      if (wr_a && addr_a[15:8] == 8'hFE) oam_a[addr_a[7:0]] <= wdata_a;
      if (wr_b && addr_b[15:8] == 8'hFE) oam_b[addr_b[7:0]] <= wdata_b;
      if (wr_c && addr_c[15:8] == 8'hFE) oam_c[addr_c[7:0]] <= wdata_c;
    end
  end

  // Selects must never overlap on any instance.
  always @(negedge clk) begin
    if ((rd_a && wr_a) || (rd_b && wr_b) || (rd_c && wr_c)) overlap++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickn(input int k);
    repeat (k) tick();
  endtask

  task automatic clear_oam(input logic [7:0] v);
    clr_val = v;
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic start_a(input logic [7:0] src);
    cfg_data = src;
    cfg_wr_a = 1'b1;
    tick();
    cfg_wr_a = 1'b0;
  endtask

  function automatic logic busy_of(input int w);
    case (w)
      0: return busy_a;
      1: return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic logic done_of(input int w);
    case (w)
      0: return done_a;
      1: return done_b;
      default: return done_c;
    endcase
  endfunction

  // Bytes of oam_a in [lo,hi) that differ from (index ^ key).
  function automatic int bad_a(input logic [7:0] key, input int lo, input int hi);
    int n = 0;
    for (int i = lo; i < hi; i++) if (oam_a[i] !== (8'(i) ^ key)) n++;
    return n;
  endfunction

  // From cycle n0 (bc0 busy cycles already seen) run to idle, counting busy cycles and done pulses.
  task automatic count_to_idle(input int w, input int n0, input int bc0,
                               output int bc, output int dc, output int dcyc);
    int n;
    bc = bc0; dc = 0; dcyc = 0; n = n0;
    while (busy_of(w) && n < 2000) begin
      bc++;
      if (done_of(w)) dc++;
      tick();
      n++;
    end
    check("idle_timeout", 32'(n < 2000), 32'd1);
    if (done_of(w)) begin
      dc++;
      dcyc = n;
    end
    tick();
    if (done_of(w)) dc++;
  endtask

  int bc, dc, dcyc, unchanged;

  initial begin
    reset = 1'b1; cfg_wr_a = 1'b0; cfg_wr_b = 1'b0; cfg_wr_c = 1'b0;
    cfg_data = 8'h00; clr = 1'b0; clr_val = 8'h00;
    for (int i = 0; i < 160; i++) begin
      ram[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;
      ram[16'hD000 + 16'(i)] = 8'(i) ^ 8'hA5;
    end
    for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h3C;
    tickn(2);
    check("rst_addr",  32'(addr_a), 32'h0);
    check("rst_rd",    32'(rd_a), 32'd0);
    check("rst_wr",    32'(wr_a), 32'd0);
    check("rst_wdata", 32'(wdata_a), 32'h0);
    check("rst_busy",  32'(busy_a), 32'd0);
    check("rst_done",  32'(done_a), 32'd0);
    reset = 1'b0;
    clear_oam(8'h00);

    // Single transfer with cycle-level checks.
    start_a(8'hC0);
    check("c1_addr", 32'(addr_a), 32'hC000);
    check("c1_rd",   32'(rd_a), 32'd1);
    check("c1_wr",   32'(wr_a), 32'd0);
    check("c1_busy", 32'(busy_a), 32'd1);
    tick();
    check("c2_addr",  32'(addr_a), 32'hFE00);
    check("c2_wr",    32'(wr_a), 32'd1);
    check("c2_rd",    32'(rd_a), 32'd0);
    check("c2_wdata", 32'(wdata_a), 32'h5A);
    tick();
    check("c3_addr", 32'(addr_a), 32'hC001);
    tick();
    check("c4_addr",  32'(addr_a), 32'hFE01);
    check("c4_wdata", 32'(wdata_a), 32'h5B);
    count_to_idle(0, 4, 3, bc, dc, dcyc);
    check("x1_busy_cycles", 32'(bc), 32'd320);
    check("x1_done_count",  32'(dc), 32'd1);
    check("x1_done_cycle",  32'(dcyc), 32'd321);
    check("x1_oam_copy",    32'(bad_a(8'h5A, 0, 160)), 32'd0);

    // Restart at cycle 50.
    clear_oam(8'h00);
    start_a(8'hC0);
    tickn(49);
    cfg_data = 8'hD0; cfg_wr_a = 1'b1;
    tick();
    cfg_wr_a = 1'b0;
    check("rs_addr", 32'(addr_a), 32'hD000);
    check("rs_rd",   32'(rd_a), 32'd1);
    check("rs_done", 32'(done_a), 32'd0);
    count_to_idle(0, 1, 0, bc, dc, dcyc);
    check("rs_busy_cycles", 32'(bc), 32'd320);
    check("rs_done_count",  32'(dc), 32'd1);
    check("rs_oam_copy",    32'(bad_a(8'hA5, 0, 160)), 32'd0);

    // Reset at cycle 100 (WR of byte 49).
    clear_oam(8'hEE);
    start_a(8'hC0);
    tickn(99);
    check("ra_pre_wr",   32'(wr_a), 32'd1);
    check("ra_pre_addr", 32'(addr_a), 32'hFE31);
    reset = 1'b1;
    tick();
    check("ra_addr",  32'(addr_a), 32'h0);
    check("ra_rd",    32'(rd_a), 32'd0);
    check("ra_wr",    32'(wr_a), 32'd0);
    check("ra_wdata", 32'(wdata_a), 32'h0);
    check("ra_busy",  32'(busy_a), 32'd0);
    check("ra_done",  32'(done_a), 32'd0);
    reset = 1'b0;
    tick();
    check("ra_written", 32'(bad_a(8'h5A, 0, 49)), 32'd0);
    unchanged = 0;
    for (int i = 50; i < 160; i++) if (oam_a[i] !== 8'hEE) unchanged++;
    check("ra_untouched", 32'(unchanged), 32'd0);
    start_a(8'hC0);
    count_to_idle(0, 1, 0, bc, dc, dcyc);
    check("ra_after_busy", 32'(bc), 32'd320);
    check("ra_after_done", 32'(dc), 32'd1);
    check("ra_after_copy", 32'(bad_a(8'h5A, 0, 160)), 32'd0);

    // cfg_wr in the final WR cycle.
    clear_oam(8'h00);
    start_a(8'hC0);
    tickn(319);
    check("fw_addr", 32'(addr_a), 32'hFE9F);
    check("fw_wr",   32'(wr_a), 32'd1);
    cfg_data = 8'hD0; cfg_wr_a = 1'b1;
    tick();
    cfg_wr_a = 1'b0;
    check("fw_last_byte", 32'(oam_a[159]), 32'hC5);
    check("fw_busy",      32'(busy_a), 32'd1);
    check("fw_done",      32'(done_a), 32'd0);
    check("fw_new_addr",  32'(addr_a), 32'hD000);
    count_to_idle(0, 1, 0, bc, dc, dcyc);
    check("fw_busy_cycles", 32'(bc), 32'd320);
    check("fw_done_count",  32'(dc), 32'd1);
    check("fw_done_cycle",  32'(dcyc), 32'd321);
    check("fw_oam_copy",    32'(bad_a(8'hA5, 0, 160)), 32'd0);

    // LEN=1 instance.
    cfg_data = 8'h00; cfg_wr_b = 1'b1;
    tick();
    cfg_wr_b = 1'b0;
    count_to_idle(1, 1, 0, bc, dc, dcyc);
    check("l1_busy_cycles", 32'(bc), 32'd2);
    check("l1_done_count",  32'(dc), 32'd1);
    check("l1_done_cycle",  32'(dcyc), 32'd3);
    check("l1_byte0",       32'(oam_b[0]), 32'h3C);
    check("l1_byte1",       32'(oam_b[1]), 32'h00);

    // LEN=256 instance.
    cfg_data = 8'h00; cfg_wr_c = 1'b1;
    tick();
    cfg_wr_c = 1'b0;
    count_to_idle(2, 1, 0, bc, dc, dcyc);
    check("l256_busy_cycles", 32'(bc), 32'd512);
    check("l256_done_count",  32'(dc), 32'd1);
    check("l256_done_cycle",  32'(dcyc), 32'd513);
    unchanged = 0;
    for (int i = 0; i < 256; i++) if (oam_c[i] !== (8'(i) ^ 8'h3C)) unchanged++;
    check("l256_copy",      32'(unchanged), 32'd0);
    check("l256_addr_hold", 32'(addr_c), 32'hFEFF);

    check("no_rd_wr_overlap", 32'(overlap), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
